// File: rtl/alu_defs_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, flag bit positions,
// FSM state encoding, instruction field positions and the commit decode.
package alu_defs;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 3;
    localparam int OP_W   = 5;
    localparam int IM_W   = 3;
    localparam int FLAG_W = 4;

    // Opcodes understood by the ALU and by the commit decode.
    localparam logic [OP_W-1:0] OP_NOP   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADD   = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND   = 5'b00010;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00011;
    localparam logic [OP_W-1:0] OP_OR    = 5'b00100;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_MOV   = 5'b00110;
    localparam logic [OP_W-1:0] OP_NOT   = 5'b01000;
    localparam logic [OP_W-1:0] OP_SAR   = 5'b01001;
    localparam logic [OP_W-1:0] OP_SLR   = 5'b01010;
    localparam logic [OP_W-1:0] OP_SAL   = 5'b01011;
    localparam logic [OP_W-1:0] OP_SLL   = 5'b01100;
    localparam logic [OP_W-1:0] OP_ROL   = 5'b01101;
    localparam logic [OP_W-1:0] OP_ROR   = 5'b01110;
    localparam logic [OP_W-1:0] OP_SHOWR = 5'b11111;

    // Bit positions inside the 4-bit {CF,ZF,SF,OF} flag vector.
    localparam int FLAG_CF = 3;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_SF = 1;
    localparam int FLAG_OF = 0;

    // Instruction word field positions; bits [1:0] carry no meaning.
    localparam int INSTR_OP_HI = 15;
    localparam int INSTR_OP_LO = 11;
    localparam int INSTR_RD_HI = 10;
    localparam int INSTR_RD_LO = 8;
    localparam int INSTR_RS_HI = 7;
    localparam int INSTR_RS_LO = 5;
    localparam int INSTR_IM_HI = 4;
    localparam int INSTR_IM_LO = 2;

    // One instruction walks IDLE -> ISSUE -> WRITE -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // What the WRITE cycle does with the captured ALU result.
    typedef enum logic [2:0] {
        CM_NONE,       // no register write, flags untouched
        CM_REG_FLAGS,  // write R[rd] and the flag register
        CM_REG_ONLY,   // write R[rd], flags untouched
        CM_SHOW,       // publish the result on show_data
        CM_ILLEGAL     // undefined opcode: nothing changes, flag it
    } commit_e;

    function automatic commit_e commit_class(input logic [OP_W-1:0] op);
        commit_e cls;
        case (op)
            OP_ADD, OP_AND, OP_SUB, OP_OR, OP_XOR,
            OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR: cls = CM_REG_FLAGS;
            OP_MOV, OP_NOT:                                 cls = CM_REG_ONLY;
            OP_NOP:                                         cls = CM_NONE;
            OP_SHOWR:                                       cls = CM_SHOW;
            default:                                        cls = CM_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/regfile_8x8.sv
// 8-entry x 8-bit register file: one synchronous write port and three
// asynchronous read ports (destination operand, source operand, debug).
module regfile_8x8
    import alu_defs::*;
#(
    parameter int               NREG    = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [IDX_W-1:0]  rs_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    input  logic [IDX_W-1:0]  dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    // Storage array: cleared on reset, one entry written per enabled edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the architectural registers have a defined reset value, so the
            // array is reset entry by entry; this keeps it in flops, not RAM macros.
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (we_i) begin
            // NOTE: state is always updated with <= so every reader in this edge
            // sees the pre-edge value regardless of process order.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports are plain muxes; a write becomes visible after its edge.
    assign rd_data_o  = mem_q[rd_addr_i];
    assign rs_data_o  = mem_q[rs_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/issue stage for the 8-bit ALU. Reads operands at accept, presents
// them and the opcode to the ALU for one cycle, captures the result and
// flags, then commits to the register file and the architectural flags.
// All sequential state around the ALU lives here.
module alu_issue_stage
    import alu_defs::*;
#(
    parameter int                NREG    = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    output logic [2:0]  alu_im,
    output logic [4:0]  alu_op,
    input  logic [7:0]  alu_res,
    input  logic        alu_cf,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    output logic [3:0]  flags,
    output logic [7:0]  show_data,
    output logic        show_valid,
    output logic        done,
    output logic        illegal_op,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    state_e state_q, state_d;

    // Latched instruction fields and operands.
    logic [OP_W-1:0]   op_q;
    logic [IDX_W-1:0]  rd_q;
    logic [IM_W-1:0]   im_q;
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;

    // ALU result and flags captured at the end of ISSUE.
    logic [DATA_W-1:0] res_q;
    logic [FLAG_W-1:0] alu_flags;
    logic [FLAG_W-1:0] alu_flags_q;

    // Architectural state and one-cycle status pulses.
    logic [FLAG_W-1:0] flags_q;
    logic [DATA_W-1:0] show_data_q;
    logic              show_valid_q;
    logic              done_q;
    logic              illegal_q;

    // Register file hookup.
    logic              rf_we;
    logic [DATA_W-1:0] rf_rd_data;
    logic [DATA_W-1:0] rf_rs_data;

    logic    accept;
    logic    in_write;
    commit_e commit_cls;
    logic    unused_instr_bits;

    assign instr_ready = (state_q == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign in_write    = (state_q == ST_WRITE);
    assign commit_cls  = commit_class(op_q);

    // Bits [1:0] of the instruction word carry no meaning.
    assign unused_instr_bits = ^instr[1:0];

    // Pack the ALU flag inputs into the architectural bit order.
    assign alu_flags[FLAG_CF] = alu_cf;
    assign alu_flags[FLAG_ZF] = alu_zf;
    assign alu_flags[FLAG_SF] = alu_sf;
    assign alu_flags[FLAG_OF] = alu_of;

    regfile_8x8 #(
        .NREG    (NREG),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clock      (clock),
        .reset_n    (reset_n),
        .we_i       (rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (res_q),
        .rd_addr_i  (instr[INSTR_RD_HI:INSTR_RD_LO]),
        .rd_data_o  (rf_rd_data),
        .rs_addr_i  (instr[INSTR_RS_HI:INSTR_RS_LO]),
        .rs_data_o  (rf_rs_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the opcode reaches the ALU only during ISSUE.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        alu_op  = OP_NOP;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                alu_op  = op_q;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Latch the instruction fields and both operands on accept; the register
    // file cannot change before this instruction commits, so no forwarding.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= OP_NOP;
            rd_q  <= '0;
            im_q  <= '0;
            in1_q <= '0;
            in2_q <= '0;
        end else if (accept) begin
            op_q  <= instr[INSTR_OP_HI:INSTR_OP_LO];
            rd_q  <= instr[INSTR_RD_HI:INSTR_RD_LO];
            im_q  <= instr[INSTR_IM_HI:INSTR_IM_LO];
            in1_q <= rf_rd_data;
            in2_q <= rf_rs_data;
        end
    end

    // Capture the ALU result and flags at the edge closing ISSUE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_q       <= '0;
            alu_flags_q <= '0;
        end else if (state_q == ST_ISSUE) begin
            res_q       <= alu_res;
            alu_flags_q <= alu_flags;
        end
    end

    // Register-file write at the edge closing WRITE, for result-producing ops.
    assign rf_we = in_write &&
                   ((commit_cls == CM_REG_FLAGS) || (commit_cls == CM_REG_ONLY));

    // Commit flags / show data and raise the one-cycle status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flags_q      <= '0;
            show_data_q  <= '0;
            show_valid_q <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            done_q       <= in_write;
            show_valid_q <= in_write && (commit_cls == CM_SHOW);
            illegal_q    <= in_write && (commit_cls == CM_ILLEGAL);
            if (in_write && (commit_cls == CM_REG_FLAGS)) begin
                flags_q <= alu_flags_q;
            end
            if (in_write && (commit_cls == CM_SHOW)) begin
                show_data_q <= res_q;
            end
        end
    end

    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign alu_im     = im_q;
    assign flags      = flags_q;
    assign show_data  = show_data_q;
    assign show_valid = show_valid_q;
    assign done       = done_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: a behavioural ALU drives the ALU
// inputs, and a transaction-level model of the stage predicts every output.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [7:0]  alu_in1, alu_in2;
    logic [2:0]  alu_im;
    logic [4:0]  alu_op;
    logic [7:0]  alu_res;
    logic        alu_cf, alu_zf, alu_sf, alu_of;
    logic [3:0]  flags;
    logic [7:0]  show_data;
    logic        show_valid, done, illegal_op;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    always #5 clock = ~clock;

    alu_issue_stage dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_im      (alu_im),
        .alu_op      (alu_op),
        .alu_res     (alu_res),
        .alu_cf      (alu_cf),
        .alu_zf      (alu_zf),
        .alu_sf      (alu_sf),
        .alu_of      (alu_of),
        .flags       (flags),
        .show_data   (show_data),
        .show_valid  (show_valid),
        .done        (done),
        .illegal_op  (illegal_op),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    localparam logic [4:0] NOP = 5'd0,  ADD = 5'd1,  OR_ = 5'd4,  MOV = 5'd6;
    localparam logic [4:0] NOT = 5'd8,  SLR = 5'd10, SLL = 5'd12, ROL = 5'd13;
    localparam logic [4:0] SHOWR = 5'd31;
    localparam logic [4:0] OPS [15] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8,
                                        5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd31};

    // Behavioural ALU: returns {res, cf, zf, sf, of}.
    function automatic logic [11:0] alu_f(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [2:0] im);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, o;
        int         s;
        s = int'(im);
        w = '0; r = '0; c = 1'b0; o = 1'b0;
        case (op)
            5'd1:  begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8];
                         o = (a[7] == b[7]) && (r[7] != a[7]); end
            5'd3:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8];
                         o = (a[7] != b[7]) && (r[7] != a[7]); end
            5'd2:  r = a & b;
            5'd4:  r = a | b;
            5'd5:  r = a ^ b;
            5'd6:  r = b;
            5'd8:  r = ~a;
            5'd9:  begin r = 8'($signed(a) >>> s); c = (s > 0) ? a[s-1] : 1'b0; end
            5'd10: begin r = a >> s;               c = (s > 0) ? a[s-1] : 1'b0; end
            5'd11, 5'd12: begin r = a << s;        c = (s > 0) ? a[8-s] : 1'b0; end
            5'd13: begin r = (a << s) | (a >> (8 - s)); c = (s > 0) ? r[0] : 1'b0; end
            5'd14: begin r = (a >> s) | (a << (8 - s)); c = (s > 0) ? r[7] : 1'b0; end
            5'd31: r = a;
            default: r = '0;
        endcase
        return {r, c, (r == 8'h00), r[7], o};
    endfunction

    always_comb begin
        {alu_res, alu_cf, alu_zf, alu_sf, alu_of} = alu_f(alu_op, alu_in1, alu_in2, alu_im);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // An instruction accepted at cycle a is presented to the ALU during cycle a,
    // commits at the edge starting cycle a+2, and the stage is free again then.
    logic [7:0]  m_r [8];
    logic [3:0]  m_flags;
    logic [7:0]  m_show;
    logic        m_done, m_showv, m_ill;
    logic [4:0]  m_op;
    logic [2:0]  m_rd, m_im;
    logic [7:0]  m_in1, m_in2;
    logic [11:0] m_alu;
    bit          busy, was_idle;
    int          cyc, acc_cyc, accepts;

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_flags = '0; m_show = '0;
        m_done = 0; m_showv = 0; m_ill = 0;
        m_op = '0; m_rd = '0; m_im = '0; m_in1 = '0; m_in2 = '0; m_alu = '0;
        busy = 0;
    endtask

    task automatic m_commit();
        logic [7:0] res;
        res = m_alu[11:4];
        if (m_op inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14}) begin
            m_r[m_rd] = res;
            m_flags   = m_alu[3:0];
        end else if (m_op inside {5'd6, 5'd8}) begin
            m_r[m_rd] = res;
        end else if (m_op == 5'd31) begin
            m_show  = res;
            m_showv = 1;
        end else if (m_op != 5'd0) begin
            m_ill = 1;
        end
        m_done = 1;
    endtask

    initial begin
        cyc = 0; accepts = 0; acc_cyc = 0;
        m_reset();
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_reset();
            end else begin
                was_idle = !busy;
                cyc++;
                m_done = 0; m_showv = 0; m_ill = 0;
                if (busy && cyc == acc_cyc + 2) begin
                    m_commit();
                    busy = 0;
                end else if (was_idle && instr_valid) begin
                    m_op    = instr[15:11];
                    m_rd    = instr[10:8];
                    m_im    = instr[4:2];
                    m_in1   = m_r[instr[10:8]];
                    m_in2   = m_r[instr[7:5]];
                    m_alu   = alu_f(m_op, m_in1, m_in2, m_im);
                    busy    = 1;
                    acc_cyc = cyc;
                    accepts++;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clock);
            check("instr_ready", instr_ready, !busy);
            check("alu_op", alu_op, (busy && cyc == acc_cyc) ? m_op : 5'd0);
            check("alu_in1", alu_in1, m_in1);
            check("alu_in2", alu_in2, m_in2);
            check("alu_im", alu_im, m_im);
            check("flags", flags, m_flags);
            check("show_data", show_data, m_show);
            check("show_valid", show_valid, m_showv);
            check("done", done, m_done);
            check("illegal_op", illegal_op, m_ill);
            check("dbg_data", dbg_data, m_r[dbg_addr]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [15:0] rand_word();
        logic [4:0] op;
        if ($urandom_range(0, 9) == 0) op = 5'($urandom);
        else                           op = OPS[$urandom_range(0, 14)];
        return {op, 11'($urandom)};
    endfunction

    // Issue one instruction and return in the cycle where done is high.
    task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] im, output int lat);
        int n;
        n = 0;
        while (!instr_ready && n < 10) begin tick(); n++; end
        check("ready_before_send", instr_ready, 1);
        instr_valid = 1'b1;
        instr = {op, rd, rs, im, 2'($urandom)};
        tick();
        instr_valid = 1'b0;
        instr = 16'($urandom);
        lat = 1;
        while (!done && lat < 8) begin
            check("ready_low_busy", instr_ready, 0);
            tick();
            lat++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic read_reg(input logic [2:0] a, input logic [7:0] exp, input string name);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ready_cnt, acc0, n;
        logic [3:0] f_before;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_addr    = '0;
        reset_n     = 1'b0;

        // Reset state.
        repeat (3) tick();
        check("rst_ready", instr_ready, 1);
        check("rst_alu_op", alu_op, 0);
        check("rst_in1", alu_in1, 0);
        check("rst_flags", flags, 0);
        check("rst_done", done, 0);
        check("rst_show", {show_valid, show_data}, 0);
        read_reg(3'd6, 8'h00, "rst_r6");
        reset_n = 1'b1;
        tick();
        check("ready_after_release", instr_ready, 1);

        // R1 = 7F, R2 = 01, then ADD R1,R2.
        send(NOT, 3'd1, 3'd0, 3'd0, lat);
        send(SLR, 3'd1, 3'd0, 3'd1, lat);
        send(NOT, 3'd2, 3'd0, 3'd0, lat);
        send(SLR, 3'd2, 3'd0, 3'd7, lat);
        read_reg(3'd1, 8'h7F, "r1_seed");
        read_reg(3'd2, 8'h01, "r2_seed");
        send(ADD, 3'd1, 3'd2, 3'd0, lat);
        check("add_latency", lat, 3);
        read_reg(3'd1, 8'h80, "add_r1");
        check("add_flags", flags, 4'b0011);
        check("model_add_r1", m_r[1], 8'h80);
        check("model_add_flags", m_flags, 4'b0011);

        // R3 = F0, MOV R4,R3, NOT R4: flags stay as set by the SLL.
        send(NOT, 3'd3, 3'd0, 3'd0, lat);
        send(SLL, 3'd3, 3'd0, 3'd4, lat);
        f_before = m_flags;
        check("sll_flags", flags, 4'b1010);
        send(MOV, 3'd4, 3'd3, 3'd0, lat);
        read_reg(3'd4, 8'hF0, "mov_r4");
        send(NOT, 3'd4, 3'd0, 3'd0, lat);
        read_reg(3'd4, 8'h0F, "not_r4");
        check("mov_not_flags_kept", flags, f_before);

        // R5 = 81, ROL R5 by 1.
        send(NOT, 3'd5, 3'd0, 3'd0, lat);
        send(SLL, 3'd5, 3'd0, 3'd7, lat);
        send(OR_, 3'd5, 3'd2, 3'd0, lat);
        read_reg(3'd5, 8'h81, "r5_seed");
        send(ROL, 3'd5, 3'd0, 3'd1, lat);
        read_reg(3'd5, 8'h03, "rol_r5");
        check("rol_flags", flags, 4'b1000);

        // SHOWR and an undefined opcode.
        send(SHOWR, 3'd5, 3'd0, 3'd0, lat);
        check("showr_valid", show_valid, 1);
        check("showr_data", show_data, 8'h03);
        check("showr_not_illegal", illegal_op, 0);
        send(5'b10101, 3'd3, 3'd3, 3'd0, lat);
        check("illegal_pulse", illegal_op, 1);
        check("illegal_no_show", show_valid, 0);
        read_reg(3'd0, 8'h00, "final_r0");
        read_reg(3'd1, 8'h80, "final_r1");
        read_reg(3'd2, 8'h01, "final_r2");
        read_reg(3'd3, 8'hF0, "final_r3");
        read_reg(3'd4, 8'h0F, "final_r4");
        read_reg(3'd5, 8'h03, "final_r5");
        read_reg(3'd7, 8'h00, "final_r7");

        // Held-valid burst: one accept every third cycle.
        tick();
        ready_cnt = 0;
        acc0 = accepts;
        for (int i = 0; i < 10; i++) begin
            instr_valid = 1'b1;
            instr = rand_word();
            if (instr_ready) ready_cnt++;
            tick();
        end
        instr_valid = 1'b0;
        check("burst_accepts", ready_cnt, 4);
        check("model_burst_accepts", accepts - acc0, 4);
        n = 0;
        while (!instr_ready && n < 8) begin tick(); n++; end
        check("burst_drained", instr_ready, 1);

        // Reset in the middle of WRITE aborts the commit of NOT R7.
        tick();
        instr_valid = 1'b1;
        instr = {NOT, 3'd7, 3'd0, 3'd0, 2'b00};
        tick();
        instr_valid = 1'b0;
        tick();
        check("in_write_ready", instr_ready, 0);
        reset_n = 1'b0;
        #1;
        check("abort_ready", instr_ready, 1);
        read_reg(3'd7, 8'h00, "abort_r7");
        read_reg(3'd1, 8'h00, "abort_r1");
        tick();
        reset_n = 1'b1;
        check("abort_no_done", done, 0);
        check("abort_flags", flags, 0);
        tick();
        read_reg(3'd7, 8'h00, "abort_r7_after");

        // Random traffic with occasional resets; the compare process checks it all.
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = rand_word();
            dbg_addr    = 3'($urandom);
            reset_n     = ($urandom_range(0, 199) != 0);
            tick();
        end
        reset_n = 1'b1;
        instr_valid = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
